wm8960_i2c_responder: RTL and testbench

I2C target that models the WM8960 codec's control port at the far end of the bus driven by the codec init sequencer. It oversamples SCL/SDA on the system clock and decodes WM8960 write frames: device address, then a 7-bit register address and 9-bit data word. Accepted writes go into an internal register file and are reported on a write-strobe port. It serves as the bus-functional codec model in loopback simulation and as an on-chip bus monitor.

---
 rtl/wm8960_i2c_responder.sv | 191 +++++++++++++++++++
 tb/tb_wm8960_i2c_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8960_i2c_responder.sv
// WM8960 control-port I2C target: oversampled SCL/SDA, write-only frames
// {dev+W, reg[6:0]+data[8], data[7:0]} committed into a 9-bit register file.
module wm8960_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 56,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       bad_addr,
  output logic       busy,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data
);

  localparam int         NS         = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] REG_LIMIT  = 8'(NUM_REGS);
  localparam logic [6:0] SWRST_ADDR = 7'h0F;

  typedef enum logic [2:0] {
    IDLE, DEVADDR, ACK_DEV, REGBYTE, ACK_REG, DATABYTE, ACK_DATA, IGNORE
  } state_t;

  logic [NS-1:0] scl_sync;
  logic [NS-1:0] sda_sync;
  logic          scl_d;
  logic          sda_d;
  logic          scl_s;
  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_evt;
  logic          stop_evt;
  logic          in_byte;
  logic          byte_done;
  logic [8:0]    data_word;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [6:0]    reg_addr;
  logic          data_msb;
  logic [8:0]    regs [NUM_REGS];

  // Line synchronizers plus edge-detect stage; free-running through reset so a
  // reset released mid-frame cannot fabricate a START or STOP.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[NS-2:0], scl_in};
    sda_sync <= {sda_sync[NS-2:0], sda_in};
    scl_d    <= scl_sync[NS-1];
    sda_d    <= sda_sync[NS-1];
  end

  // Bus event decode from the synchronized lines.
  always_comb begin
    scl_s     = scl_sync[NS-1];
    sda_s     = sda_sync[NS-1];
    scl_rise  = scl_s & ~scl_d;
    scl_fall  = ~scl_s & scl_d;
    start_evt = scl_s & scl_d & sda_d & ~sda_s;
    stop_evt  = scl_s & scl_d & ~sda_d & sda_s;
    in_byte   = (state == DEVADDR) || (state == REGBYTE) || (state == DATABYTE);
    byte_done = in_byte & scl_fall & (bit_cnt == 4'd8);
    data_word = {data_msb, shift};
  end

  // Frame FSM, ACK drive, commit strobes and register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      reg_addr <= 7'd0;
      data_msb <= 1'b0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      bad_addr <= 1'b0;
      busy     <= 1'b0;
      wr_addr  <= 7'd0;
      wr_data  <= 9'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
    end else begin
      wr_valid <= 1'b0;
      bad_addr <= 1'b0;
      if (in_byte && scl_rise && (bit_cnt != 4'd8)) begin
        shift   <= {shift[6:0], sda_s};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (stop_evt) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_evt) begin
        state   <= DEVADDR;
        busy    <= 1'b1;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
          end
          DEVADDR: begin
            if (byte_done) begin
              bit_cnt <= 4'd0;
              if (shift == {DEV_ADDR, 1'b0}) begin
                state  <= ACK_DEV;
                sda_oe <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ACK_DEV: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= REGBYTE;
            end
          end
          REGBYTE: begin
            if (byte_done) begin
              bit_cnt  <= 4'd0;
              reg_addr <= shift[7:1];
              data_msb <= shift[0];
              sda_oe   <= 1'b1;
              state    <= ACK_REG;
            end
          end
          ACK_REG: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= DATABYTE;
            end
          end
          DATABYTE: begin
            if (byte_done) begin
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b1;
              state   <= ACK_DATA;
              // Software reset wins over the range check so it works for any NUM_REGS.
              if (reg_addr == SWRST_ADDR) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
                wr_valid <= 1'b1;
                wr_addr  <= reg_addr;
                wr_data  <= data_word;
              end else if ({1'b0, reg_addr} < REG_LIMIT) begin
                regs[reg_addr[AW-1:0]] <= data_word;
                wr_valid <= 1'b1;
                wr_addr  <= reg_addr;
                wr_data  <= data_word;
              end else begin
                bad_addr <= 1'b1;
              end
            end
          end
          ACK_DATA: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= IGNORE;
            end
          end
          IGNORE: begin
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered read port; a same-cycle write is visible on the following read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= 9'd0;
    end else if ({1'b0, rd_addr} < REG_LIMIT) begin
      rd_data <= regs[rd_addr[AW-1:0]];
    end else begin
      rd_data <= 9'd0;
    end
  end

endmodule

// File: tb/tb_wm8960_i2c_responder.sv
// Bench for wm8960_i2c_responder: bit-banged I2C master, table vectors,
// random frames against a register-map model, and hand-written corner cases.
module tb_wm8960_i2c_responder;

  localparam int Q    = 4;   // clk cycles per quarter SCL period
  localparam int NREG = 56;

  logic       clk;
  logic       reset_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       bad_addr;
  logic       busy;
  logic [6:0] rd_addr;
  logic [8:0] rd_data;

  assign sda_line = sda_m & ~sda_oe;

  wm8960_i2c_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .bad_addr(bad_addr), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: pulse counts, first-cycle timestamp, width violations.
  int   wr_cnt = 0, bad_cnt = 0, width_err = 0, pulse_cyc = 0;
  logic prev_wv = 1'b0, prev_ba = 1'b0;
  always @(negedge clk) begin
    prev_wv <= wr_valid;
    prev_ba <= bad_addr;
    if (wr_valid) wr_cnt <= wr_cnt + 1;
    if (bad_addr) bad_cnt <= bad_cnt + 1;
    if ((wr_valid || bad_addr) && !(prev_wv || prev_ba)) pulse_cyc <= cyc;
    if ((wr_valid && prev_wv) || (bad_addr && prev_ba)) width_err <= width_err + 1;
  end

  int total = 0, bad = 0;
  int last_fall = 0, byte_fall = 0;

  logic [8:0] m_regs [NREG];
  logic [6:0] m_last_addr;
  logic [8:0] m_last_data;

  typedef struct {
    logic [7:0] dev;
    logic [6:0] ra;
    logic [8:0] d;
    logic [2:0] eack;
    int         ewr;
    int         ebad;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic oe_seen);
    sda_m = b;    clk_wait(Q);
    scl_m = 1'b1; clk_wait(Q);
    oe_seen = sda_oe;
    clk_wait(Q);
    scl_m = 1'b0;
    last_fall = cyc;
    clk_wait(Q);
  endtask

  task automatic send_start();
    sda_m = 1'b1; clk_wait(Q);
    scl_m = 1'b1; clk_wait(Q);
    sda_m = 1'b0; clk_wait(Q);
    scl_m = 1'b0; clk_wait(Q);
  endtask

  task automatic send_stop();
    sda_m = 1'b0; clk_wait(Q);
    scl_m = 1'b1; clk_wait(Q);
    sda_m = 1'b1; clk_wait(2 * Q);
  endtask

  // Eight data bits (target must not drive) then the ACK slot.
  task automatic send_byte(input logic [7:0] b, output logic ack, output int oe_err);
    logic o;
    oe_err = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], o);
      if (o) oe_err++;
    end
    byte_fall = last_fall;
    send_bit(1'b1, o);
    ack = o;
  endtask

  task automatic read_reg(input int a, output logic [8:0] v);
    rd_addr = 7'(a);
    clk_wait(1);
    v = rd_data;
  endtask

  // Reference model of the WM8960 register map.
  task automatic model_apply(input logic [7:0] dev, input logic [6:0] ra, input logic [8:0] d,
                             output logic [2:0] eack, output int ewr, output int ebad);
    int idx;
    idx = int'(ra);
    eack = 3'b000; ewr = 0; ebad = 0;
    if (dev[7:1] == 7'h1A && dev[0] == 1'b0) begin
      eack = 3'b111;
      if (idx == 15) begin
        foreach (m_regs[k]) m_regs[k] = 9'd0;
        ewr = 1; m_last_addr = ra; m_last_data = d;
      end else if (idx < NREG) begin
        m_regs[idx] = d;
        ewr = 1; m_last_addr = ra; m_last_data = d;
      end else begin
        ebad = 1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] dev, input logic [6:0] ra,
                           input logic [8:0] d, input logic [2:0] eack, input int ewr, input int ebad);
    logic [2:0] acks;
    logic       a;
    int         e, oe_err, w0, b0, fall, idx;
    logic [8:0] rv;
    w0 = wr_cnt; b0 = bad_cnt; oe_err = 0;
    send_start();
    send_byte(dev, a, e);          acks[2] = a; oe_err += e;
    send_byte({ra, d[8]}, a, e);   acks[1] = a; oe_err += e;
    send_byte(d[7:0], a, e);       acks[0] = a; oe_err += e;
    fall = byte_fall;
    send_stop();
    clk_wait(4);
    check($sformatf("%s acks", tag), acks, eack);
    check($sformatf("%s oe_on_data", tag), oe_err, 0);
    check($sformatf("%s wr_pulses", tag), wr_cnt - w0, ewr);
    check($sformatf("%s bad_pulses", tag), bad_cnt - b0, ebad);
    check($sformatf("%s wr_addr", tag), wr_addr, m_last_addr);
    check($sformatf("%s wr_data", tag), wr_data, m_last_data);
    check($sformatf("%s busy_after_stop", tag), busy, 0);
    if (ewr + ebad > 0) check($sformatf("%s strobe_latency", tag), pulse_cyc - fall, 3);
    idx = int'(ra);
    if (idx < NREG) begin
      read_reg(idx, rv);
      check($sformatf("%s rd_data", tag), rv, m_regs[idx]);
    end
  endtask

  task automatic sweep(input string tag);
    logic [8:0] rv;
    for (int k = 0; k < NREG; k++) begin
      read_reg(k, rv);
      check($sformatf("%s reg%0d", tag, k), rv, m_regs[k]);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ea;
    int         ew, eb, e, w0, b0, n;
    logic       a, o;
    logic [7:0] db;
    logic [8:0] rv;
    logic [7:0] rdev;
    logic [6:0] rra;
    logic [8:0] rd9;

    vecs[0] = '{8'h34, 7'h07, 9'h00A, 3'b111, 1, 0};
    vecs[1] = '{8'h36, 7'h07, 9'h155, 3'b000, 0, 0};
    vecs[2] = '{8'h35, 7'h07, 9'h155, 3'b000, 0, 0};
    vecs[3] = '{8'h34, 7'h40, 9'h1FF, 3'b111, 0, 1};
    vecs[4] = '{8'h34, 7'h05, 9'h155, 3'b111, 1, 0};
    vecs[5] = '{8'h34, 7'h37, 9'h0AA, 3'b111, 1, 0};
    vecs[6] = '{8'h34, 7'h38, 9'h001, 3'b111, 0, 1};
    vecs[7] = '{8'h34, 7'h00, 9'h1FF, 3'b111, 1, 0};
    vecs[8] = '{8'h34, 7'h0F, 9'h000, 3'b111, 1, 0};
    foreach (m_regs[k]) m_regs[k] = 9'd0;
    m_last_addr = 7'd0;
    m_last_data = 9'd0;

    reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 7'd0;
    clk_wait(5);
    check("rst sda_oe", sda_oe, 0);
    check("rst wr_valid", wr_valid, 0);
    check("rst bad_addr", bad_addr, 0);
    check("rst busy", busy, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst rd_data", rd_data, 0);
    reset_n = 1'b1;
    clk_wait(4);

    for (int i = 0; i < 9; i++) begin
      model_apply(vecs[i].dev, vecs[i].ra, vecs[i].d, ea, ew, eb);
      run_frame($sformatf("vec%0d", i), vecs[i].dev, vecs[i].ra, vecs[i].d,
                vecs[i].eack, vecs[i].ewr, vecs[i].ebad);
    end
    read_reg(5, rv);
    check("swrst reg05", rv, 0);
    sweep("after_swrst");

    // ACK timing on the device byte, then repeated START after the register byte.
    w0 = wr_cnt;
    send_start();
    check("busy after start", busy, 1);
    db = 8'h34;
    for (int i = 7; i >= 1; i--) send_bit(db[i], o);
    sda_m = db[0]; clk_wait(Q);
    scl_m = 1'b1;  clk_wait(2 * Q);
    scl_m = 1'b0;  clk_wait(2);
    check("ack not before 3 clk", sda_oe, 0);
    clk_wait(1);
    check("ack at 3 clk", sda_oe, 1);
    clk_wait(Q - 3);
    send_bit(1'b1, o);
    check("rs dev ack", o, 1);
    send_byte({7'h09, 1'b1}, a, e);
    check("rs reg ack", a, 1);
    check("rs no commit yet", wr_cnt - w0, 0);
    model_apply(8'h34, 7'h02, 9'h123, ea, ew, eb);
    run_frame("rstart", 8'h34, 7'h02, 9'h123, ea, ew, eb);
    read_reg(9, rv);
    check("rs reg09 untouched", rv, m_regs[9]);

    // STOP after 12 bits: discarded.
    w0 = wr_cnt; b0 = bad_cnt;
    send_start();
    send_byte(8'h34, a, e);
    db = 8'h05;
    for (int i = 7; i >= 4; i--) send_bit(db[i], o);
    send_stop();
    clk_wait(4);
    check("partial wr", wr_cnt - w0, 0);
    check("partial bad", bad_cnt - b0, 0);
    check("partial busy", busy, 0);

    for (int r = 0; r < 16; r++) begin
      rdev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      rra  = 7'($urandom_range(0, 127));
      rd9  = 9'($urandom);
      model_apply(rdev, rra, rd9, ea, ew, eb);
      run_frame($sformatf("rand%0d", r), rdev, rra, rd9, ea, ew, eb);
    end
    sweep("after_random");

    // Reset during the DATABYTE ACK slot.
    send_start();
    send_byte(8'h34, a, e);
    send_byte({7'h03, 1'b1}, a, e);
    db = 8'h5A;
    for (int i = 7; i >= 0; i--) send_bit(db[i], o);
    model_apply(8'h34, 7'h03, 9'h15A, ea, ew, eb);
    sda_m = 1'b1;
    n = 0;
    while (!sda_oe && n < 20) begin clk_wait(1); n++; end
    check("midack oe driven", sda_oe, 1);
    reset_n = 1'b0;
    clk_wait(1);
    check("midrst sda_oe", sda_oe, 0);
    check("midrst busy", busy, 0);
    check("midrst wr_addr", wr_addr, 0);
    check("midrst wr_data", wr_data, 0);
    check("midrst wr_valid", wr_valid, 0);
    check("midrst bad_addr", bad_addr, 0);
    check("midrst rd_data", rd_data, 0);
    foreach (m_regs[k]) m_regs[k] = 9'd0;
    m_last_addr = 7'd0;
    m_last_data = 9'd0;
    clk_wait(3);
    reset_n = 1'b1;
    clk_wait(2);
    scl_m = 1'b1; clk_wait(2 * Q);
    scl_m = 1'b0; clk_wait(Q);
    w0 = wr_cnt; b0 = bad_cnt;
    send_byte(8'h34, a, e);
    check("post-rst no ack", a, 0);
    check("post-rst oe idle", e, 0);
    send_byte(8'h0E, a, e);
    check("post-rst no ack 2", a, 0);
    send_stop();
    clk_wait(4);
    check("post-rst wr", wr_cnt - w0, 0);
    check("post-rst bad", bad_cnt - b0, 0);
    check("post-rst busy", busy, 0);
    model_apply(8'h34, 7'h07, 9'h0A5, ea, ew, eb);
    run_frame("rearm", 8'h34, 7'h07, 9'h0A5, ea, ew, eb);
    sweep("final");
    check("strobe width", width_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
